// File: rtl/audio_attenuator_pkg.sv
// Shared types and helpers for the audio attenuator.
// Provides the gain/code matrix struct, the datapath state type, the
// Q1.15 saturation and ramp helpers, and the attenuation gain table builder.
package audio_attenuator_pkg;

  localparam logic [15:0] kGainUnity = 16'h8000;
  localparam logic [7:0]  kAttenMute = 8'h80;

  // Holds either four attenuation codes (zero-extended) or four Q1.15 gains.
  typedef struct packed {
    logic [15:0] ll;
    logic [15:0] lr;
    logic [15:0] rl;
    logic [15:0] rr;
  } atten_matrix_s;

  localparam atten_matrix_s kGainReset =
    '{ll: kGainUnity, lr: 16'h0000, rl: 16'h0000, rr: kGainUnity};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_LL,
    S_MUL_RL,
    S_MUL_LR,
    S_MUL_RR,
    S_OUT
  } dp_state_e;

  // Move cur toward tgt by at most step.
  function automatic logic [15:0] ramp_toward(input logic [15:0] cur,
                                               input logic [15:0] tgt,
                                               input logic [15:0] step);
    if (cur < tgt) return ((tgt - cur) > step) ? (cur + step) : tgt;
    else           return ((cur - tgt) > step) ? (cur - step) : tgt;
  endfunction

  // acc >>> 15 (floor), clamped to the signed 16-bit range.
  function automatic logic [15:0] saturate_q15(input logic signed [33:0] acc);
    logic signed [33:0] shifted;
    shifted = acc >>> 15;
    if (shifted > 34'sd32767)  return 16'h7FFF;
    if (shifted < -34'sd32768) return 16'h8000;
    return shifted[15:0];
  endfunction

  // round(32768 * 10^(-c/40)) for c = 0..127, in pure integer arithmetic.
  // The per-step ratio 10^(-1/40) is found in Q48 by bisection on r^40 = 0.1,
  // then gains are successive powers of it rounded to Q1.15.
  function automatic logic [127:0][15:0] build_gain_table();
    logic [127:0][15:0] table_q;
    logic [95:0] one, tenth, lo, hi, mid, pw;
    one   = 96'd1 << 48;
    tenth = one / 96'd10;
    lo    = '0;
    hi    = one;
    for (int unsigned it = 0; it < 48; it++) begin
      mid = (lo + hi) >> 1;
      pw  = one;
      for (int unsigned k = 0; k < 40; k++) pw = (pw * mid) >> 48;
      if (pw > tenth) hi = mid;
      else            lo = mid;
    end
    pw = one;
    for (int unsigned c = 0; c < 128; c++) begin
      table_q[c] = 16'((pw + (96'd1 << 32)) >> 33);
      pw = (pw * lo) >> 48;
    end
    return table_q;
  endfunction

endpackage

// File: rtl/audio_attenuator_gain_rom.sv
// 128 x 16 attenuation gain ROM, registered read (1-cycle latency).
// Ports: clk - clock; i_addr - attenuation code 0..127;
//        o_data - Q1.15 gain for the code addressed on the previous cycle.
module audio_gain_rom
  import audio_attenuator_pkg::*;
(
  input  logic        clk,
  input  logic [6:0]  i_addr,
  output logic [15:0] o_data
);

  localparam logic [127:0][15:0] kGainTable = build_gain_table();

  always_ff @(posedge clk) begin
    o_data <= kGainTable[i_addr];
  end

endmodule

// File: rtl/audio_attenuator.sv
// Stereo 2x2 attenuation matrix with ramped gains and a shared multiplier.
// Ports: clk/reset (sync, active-high); in_left/in_right/in_strobe - input
// sample pair; atten_ll/lr/rl/rr + atten_apply - new attenuation codes;
// mute - force all targets to 0; out_left/out_right/out_strobe - result pair;
// overrun - pulse when an input strobe is dropped while busy.
module audio_attenuator
  import audio_attenuator_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  input  logic        in_strobe,
  input  logic [7:0]  atten_ll,
  input  logic [7:0]  atten_lr,
  input  logic [7:0]  atten_rl,
  input  logic [7:0]  atten_rr,
  input  logic        atten_apply,
  input  logic        mute,
  output logic [15:0] out_left,
  output logic [15:0] out_right,
  output logic        out_strobe,
  output logic        overrun
);

  localparam logic [15:0] kStep = 16'(RAMP_STEP);

  dp_state_e          r_state, w_state_nxt;
  logic signed [15:0] r_in_l, r_in_r;
  logic signed [33:0] r_acc_l, r_acc_r;
  atten_matrix_s      r_tgt, r_cur, r_codes, w_eff;

  logic               r_conv_busy, r_rd_valid, r_rd_mute;
  logic [1:0]         r_conv_idx, r_rd_idx;
  logic [15:0]        w_code, w_rom_data, w_rom_gain;

  logic signed [15:0] w_mul_a;
  logic [15:0]        w_mul_g;
  logic signed [32:0] w_product;
  logic signed [33:0] w_prod_ext;

  // ---------------- converter sequencer ----------------
  // The apply cycle addresses the ROM straight from the input code so the
  // ll lookup starts without waiting for the code latch.
  always_comb begin
    w_code = {8'h00, atten_ll};
    if (!atten_apply) begin
      unique case (r_conv_idx)
        2'd1:    w_code = r_codes.lr;
        2'd2:    w_code = r_codes.rl;
        2'd3:    w_code = r_codes.rr;
        default: w_code = r_codes.ll;
      endcase
    end
  end

  audio_gain_rom u_rom (
    .clk    (clk),
    .i_addr (w_code[6:0]),
    .o_data (w_rom_data)
  );

  assign w_rom_gain = r_rd_mute ? '0 : w_rom_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_codes     <= '0;
      r_conv_busy <= 1'b0;
      r_conv_idx  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_idx    <= '0;
      r_rd_mute   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (atten_apply) begin
        r_codes     <= '{ll: {8'h00, atten_ll}, lr: {8'h00, atten_lr},
                         rl: {8'h00, atten_rl}, rr: {8'h00, atten_rr}};
        r_conv_busy <= 1'b1;
        r_conv_idx  <= 2'd1;
        r_rd_valid  <= 1'b1;
        r_rd_idx    <= 2'd0;
        r_rd_mute   <= (w_code >= {8'h00, kAttenMute});
      end else if (r_conv_busy) begin
        r_rd_valid  <= 1'b1;
        r_rd_idx    <= r_conv_idx;
        r_rd_mute   <= (w_code >= {8'h00, kAttenMute});
        r_conv_idx  <= r_conv_idx + 2'd1;
        if (r_conv_idx == 2'd3) r_conv_busy <= 1'b0;
      end
    end
  end

  // ---------------- gains: targets and ramp ----------------
  assign w_eff = mute ? '0 : r_tgt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tgt <= kGainReset;
      r_cur <= kGainReset;
    end else begin
      // A fresh apply discards the lookup still in flight from the old codes.
      if (r_rd_valid && !atten_apply) begin
        unique case (r_rd_idx)
          2'd0: r_tgt.ll <= w_rom_gain;
          2'd1: r_tgt.lr <= w_rom_gain;
          2'd2: r_tgt.rl <= w_rom_gain;
          2'd3: r_tgt.rr <= w_rom_gain;
        endcase
      end
      if (r_state == S_OUT) begin
        r_cur.ll <= ramp_toward(r_cur.ll, w_eff.ll, kStep);
        r_cur.lr <= ramp_toward(r_cur.lr, w_eff.lr, kStep);
        r_cur.rl <= ramp_toward(r_cur.rl, w_eff.rl, kStep);
        r_cur.rr <= ramp_toward(r_cur.rr, w_eff.rr, kStep);
      end
    end
  end

  // ---------------- datapath FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (in_strobe) w_state_nxt = S_MUL_LL;
      S_MUL_LL: w_state_nxt = S_MUL_RL;
      S_MUL_RL: w_state_nxt = S_MUL_LR;
      S_MUL_LR: w_state_nxt = S_MUL_RR;
      S_MUL_RR: w_state_nxt = S_OUT;
      S_OUT:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Shared 16x17 signed multiplier; gains are unsigned, so zero-pad to 17 bits.
  always_comb begin
    w_mul_a = r_in_l;
    w_mul_g = r_cur.ll;
    unique case (r_state)
      S_MUL_RL: begin w_mul_a = r_in_r; w_mul_g = r_cur.rl; end
      S_MUL_LR: begin w_mul_a = r_in_l; w_mul_g = r_cur.lr; end
      S_MUL_RR: begin w_mul_a = r_in_r; w_mul_g = r_cur.rr; end
      default:  ;
    endcase
  end

  assign w_product  = w_mul_a * $signed({1'b0, w_mul_g});
  assign w_prod_ext = {w_product[32], w_product};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_l     <= '0;
      r_in_r     <= '0;
      r_acc_l    <= '0;
      r_acc_r    <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_strobe <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      overrun    <= in_strobe && (r_state != S_IDLE);
      unique case (r_state)
        S_IDLE: if (in_strobe) begin
          r_in_l <= in_left;
          r_in_r <= in_right;
        end
        S_MUL_LL: r_acc_l <= w_prod_ext;
        S_MUL_RL: r_acc_l <= r_acc_l + w_prod_ext;
        S_MUL_LR: r_acc_r <= w_prod_ext;
        S_MUL_RR: r_acc_r <= r_acc_r + w_prod_ext;
        S_OUT: begin
          out_left   <= saturate_q15(r_acc_l);
          out_right  <= saturate_q15(r_acc_r);
          out_strobe <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
